// File: rtl/dvi_pkg.sv
// Shared constants and helpers for the DVI/TMDS encoder: control tokens,
// default clock-channel symbol, disparity width and an 8-bit popcount.
package dvi_pkg;

  localparam int DISP_W = 5;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam logic [9:0] CLK_SYMBOL_DEFAULT = 10'b1111100000;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS channel: registered transition-minimisation stage followed by a
// registered DC-balance stage that owns the running disparity counter.
module tmds_channel
  import dvi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_data,
  input  logic       i_de,
  input  logic       i_c0,
  input  logic       i_c1,
  output logic [9:0] o_symbol
);

  function automatic logic [8:0] minimise_transitions(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  logic [8:0] r_qm;
  logic       r_de;
  logic       r_c0;
  logic       r_c1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_qm <= '0;
      r_de <= 1'b0;
      r_c0 <= 1'b0;
      r_c1 <= 1'b0;
    end else begin
      r_qm <= minimise_transitions(i_data);
      r_de <= i_de;
      r_c0 <= i_c0;
      r_c1 <= i_c1;
    end
  end

  logic signed [DISP_W-1:0] r_cnt;
  logic [9:0]               r_symbol;
  logic [3:0]               w_n1q;
  logic signed [DISP_W-1:0] w_diff;
  logic signed [DISP_W-1:0] w_q8_bias;
  logic signed [DISP_W-1:0] w_cnt_nxt;
  logic [9:0]               w_sym;

  // w_diff is N1q-N0q = 2*N1q-8; 5-bit wraparound is exact because the result fits in -8..+8.
  always_comb begin
    w_n1q     = popcount8(r_qm[7:0]);
    w_diff    = DISP_W'({w_n1q, 1'b0}) - DISP_W'(8);
    w_q8_bias = r_qm[8] ? DISP_W'(2) : '0;
    w_sym     = CTRL_TOKEN_00;
    w_cnt_nxt = '0;
    if (!r_de) begin
      case ({r_c1, r_c0})
        2'b00:   w_sym = CTRL_TOKEN_00;
        2'b01:   w_sym = CTRL_TOKEN_01;
        2'b10:   w_sym = CTRL_TOKEN_10;
        default: w_sym = CTRL_TOKEN_11;
      endcase
    end else if ((r_cnt == '0) || (w_n1q == 4'd4)) begin
      w_sym     = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
      w_cnt_nxt = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
    end else if (((r_cnt > 0) && (w_n1q > 4'd4)) || ((r_cnt < 0) && (w_n1q < 4'd4))) begin
      w_sym     = {1'b1, r_qm[8], ~r_qm[7:0]};
      w_cnt_nxt = r_cnt + w_q8_bias - w_diff;
    end else begin
      w_sym     = {1'b0, r_qm[8], r_qm[7:0]};
      w_cnt_nxt = r_cnt + w_diff - (DISP_W'(2) - w_q8_bias);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_symbol <= CTRL_TOKEN_00;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_symbol <= w_sym;
    end
  end

  assign o_symbol = r_symbol;

endmodule

// File: rtl/dvi_encoder.sv
// 24-bit RGB + sync to three TMDS channels plus constant clock symbol.
// Define DVI_INPUT_REG_EN to add an input register stage (latency 3 instead of 2).
module dvi_encoder
  import dvi_pkg::*;
#(
  parameter logic [9:0] CLK_SYMBOL = CLK_SYMBOL_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] vga_r,
  input  logic [7:0] vga_g,
  input  logic [7:0] vga_b,
  input  logic       vga_hs,
  input  logic       vga_vs,
  input  logic       vga_de,
  output logic [9:0] tmds_b,
  output logic [9:0] tmds_g,
  output logic [9:0] tmds_r,
  output logic [9:0] tmds_clk
);

  logic [7:0] w_r;
  logic [7:0] w_g;
  logic [7:0] w_b;
  logic       w_hs;
  logic       w_vs;
  logic       w_de;

`ifdef DVI_INPUT_REG_EN
  // Isolates the video stage's colour muxing from the encoder's popcount logic.
  logic [7:0] r_r;
  logic [7:0] r_g;
  logic [7:0] r_b;
  logic       r_hs;
  logic       r_vs;
  logic       r_de;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
      r_hs <= 1'b0;
      r_vs <= 1'b0;
      r_de <= 1'b0;
    end else begin
      r_r  <= vga_r;
      r_g  <= vga_g;
      r_b  <= vga_b;
      r_hs <= vga_hs;
      r_vs <= vga_vs;
      r_de <= vga_de;
    end
  end

  assign w_r  = r_r;
  assign w_g  = r_g;
  assign w_b  = r_b;
  assign w_hs = r_hs;
  assign w_vs = r_vs;
  assign w_de = r_de;
`else
  assign w_r  = vga_r;
  assign w_g  = vga_g;
  assign w_b  = vga_b;
  assign w_hs = vga_hs;
  assign w_vs = vga_vs;
  assign w_de = vga_de;
`endif

  tmds_channel u_ch_b (
    .clk      (clk),
    .reset    (reset),
    .i_data   (w_b),
    .i_de     (w_de),
    .i_c0     (w_hs),
    .i_c1     (w_vs),
    .o_symbol (tmds_b)
  );

  tmds_channel u_ch_g (
    .clk      (clk),
    .reset    (reset),
    .i_data   (w_g),
    .i_de     (w_de),
    .i_c0     (1'b0),
    .i_c1     (1'b0),
    .o_symbol (tmds_g)
  );

  tmds_channel u_ch_r (
    .clk      (clk),
    .reset    (reset),
    .i_data   (w_r),
    .i_de     (w_de),
    .i_c0     (1'b0),
    .i_c1     (1'b0),
    .o_symbol (tmds_r)
  );

  assign tmds_clk = CLK_SYMBOL;

endmodule

// File: tb/tb_dvi_encoder.sv
// Directed + randomized bench for dvi_encoder against a symbol-level reference model.
// Define DVI_INPUT_REG_EN to match a DUT built with the input register stage.
module tb_dvi_encoder;

`ifdef DVI_INPUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam logic [9:0] T00   = 10'b1101010100;
  localparam logic [9:0] T01   = 10'b0010101011;
  localparam logic [9:0] T10   = 10'b0101010100;
  localparam logic [9:0] T11   = 10'b1010101011;
  localparam logic [9:0] CLKS  = 10'b1111100000;
  localparam int         LOG_N = 8192;

  logic       clk;
  logic       reset;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_de;
  logic [9:0] tmds_b, tmds_g, tmds_r, tmds_clk;

  dvi_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .vga_r    (vga_r),
    .vga_g    (vga_g),
    .vga_b    (vga_b),
    .vga_hs   (vga_hs),
    .vga_vs   (vga_vs),
    .vga_de   (vga_de),
    .tmds_b   (tmds_b),
    .tmds_g   (tmds_g),
    .tmds_r   (tmds_r),
    .tmds_clk (tmds_clk)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard: expected {r,g,b} per output cycle, tagged with applied index (-1 = pipeline fill)
  logic [29:0] exp_q[$];
  int          idx_q[$];
  int          n_app = 0;
  int          m_cnt[3];
  bit          de_log[LOG_N];
  int          mc_log[LOG_N][3];
  logic [9:0]  obs_b[LOG_N];
  logic [9:0]  obs_g[LOG_N];
  logic [9:0]  obs_r[LOG_N];
  int          acc[3];
  bit          prev_de;

  function automatic int ones10(input logic [9:0] s);
    int n = 0;
    for (int i = 0; i < 10; i++) n += int'(s[i]);
    return n;
  endfunction

  // Reference: spec rules on whole words; disparity tracked as the ones-minus-zeros of emitted symbols.
  task automatic ref_enc(input logic [7:0] d, input bit de, input bit c0, input bit c1,
                         input int cin, output int cout, output logic [9:0] sym);
    int         n1;
    int         n1q;
    bit         xnor_mode;
    bit         invert;
    logic [8:0] qm;
    if (!de) begin
      case ({c1, c0})
        2'b00: sym = T00;
        2'b01: sym = T01;
        2'b10: sym = T10;
        default: sym = T11;
      endcase
      cout = 0;
      return;
    end
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(d[i]);
    xnor_mode = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xnor_mode ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xnor_mode;
    n1q = 0;
    for (int i = 0; i < 8; i++) n1q += int'(qm[i]);
    if (cin == 0 || n1q == 4) invert = !qm[8];
    else invert = (cin > 0 && n1q > 4) || (cin < 0 && n1q < 4);
    sym  = {invert, qm[8], invert ? ~qm[7:0] : qm[7:0]};
    cout = cin + 2 * ones10(sym) - 10;
  endtask

  task automatic check_out();
    logic [29:0]       e;
    int                id;
    logic signed [4:0] cb, cg, cr;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    e  = exp_q.pop_front();
    id = idx_q.pop_front();
    n_vec++;
    assert (tmds_b === e[9:0]) else begin
      n_err++;
      $error("FAIL tmds_b id=%0d observed=%b expected=%b", id, tmds_b, e[9:0]);
    end
    n_vec++;
    assert (tmds_g === e[19:10]) else begin
      n_err++;
      $error("FAIL tmds_g id=%0d observed=%b expected=%b", id, tmds_g, e[19:10]);
    end
    n_vec++;
    assert (tmds_r === e[29:20]) else begin
      n_err++;
      $error("FAIL tmds_r id=%0d observed=%b expected=%b", id, tmds_r, e[29:20]);
    end
    n_vec++;
    assert (tmds_clk === CLKS) else begin
      n_err++;
      $error("FAIL tmds_clk id=%0d observed=%b expected=%b", id, tmds_clk, CLKS);
    end
    cb = dut.u_ch_b.r_cnt;
    cg = dut.u_ch_g.r_cnt;
    cr = dut.u_ch_r.r_cnt;
    n_vec++;
    assert (cb >= -8 && cb <= 8 && cg >= -8 && cg <= 8 && cr >= -8 && cr <= 8) else begin
      n_err++;
      $error("FAIL cnt_range id=%0d observed=%0d/%0d/%0d expected=-8..8", id, cb, cg, cr);
    end
    if (id >= 0) begin
      obs_b[id] = tmds_b;
      obs_g[id] = tmds_g;
      obs_r[id] = tmds_r;
      if (de_log[id]) begin
        acc[0] += 2 * ones10(tmds_b) - 10;
        acc[1] += 2 * ones10(tmds_g) - 10;
        acc[2] += 2 * ones10(tmds_r) - 10;
      end else if (prev_de) begin
        for (int c = 0; c < 3; c++) begin
          n_vec++;
          assert (acc[c] === mc_log[id-1][c]) else begin
            n_err++;
            $error("FAIL run_disparity ch=%0d id=%0d observed=%0d expected=%0d", c, id, acc[c], mc_log[id-1][c]);
          end
          acc[c] = 0;
        end
      end
      prev_de = de_log[id];
    end
  endtask

  // driver: apply one pixel-clock of inputs, then compare one output cycle at the negedge
  task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input bit hs, input bit vs, input bit de);
    logic [9:0] sr, sg, sb;
    int         nc;
    vga_r  = r;
    vga_g  = g;
    vga_b  = b;
    vga_hs = hs;
    vga_vs = vs;
    vga_de = de;
    ref_enc(b, de, hs, vs, m_cnt[0], nc, sb); m_cnt[0] = nc;
    ref_enc(g, de, 1'b0, 1'b0, m_cnt[1], nc, sg); m_cnt[1] = nc;
    ref_enc(r, de, 1'b0, 1'b0, m_cnt[2], nc, sr); m_cnt[2] = nc;
    exp_q.push_back({sr, sg, sb});
    idx_q.push_back(n_app);
    de_log[n_app] = de;
    for (int c = 0; c < 3; c++) mc_log[n_app][c] = m_cnt[c];
    n_app++;
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic blank(input int n, input bit hs, input bit vs);
    for (int i = 0; i < n; i++) drive(8'h00, 8'h00, 8'h00, hs, vs, 1'b0);
  endtask

  task automatic restart_model();
    exp_q.delete();
    idx_q.delete();
    for (int c = 0; c < 3; c++) begin
      m_cnt[c] = 0;
      acc[c]   = 0;
    end
    prev_de = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      exp_q.push_back({T00, T00, T00});
      idx_q.push_back(-1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    assert (tmds_b === T00 && tmds_g === T00 && tmds_r === T00) else begin
      n_err++;
      $error("FAIL %s observed=%b/%b/%b expected=%b", tag, tmds_b, tmds_g, tmds_r, T00);
    end
    n_vec++;
    assert (tmds_clk === CLKS) else begin
      n_err++;
      $error("FAIL %s_clk observed=%b expected=%b", tag, tmds_clk, CLKS);
    end
  endtask

  int ia, ig;

  initial begin
    reset  = 1'b1;
    vga_r  = '0;
    vga_g  = '0;
    vga_b  = '0;
    vga_hs = 1'b0;
    vga_vs = 1'b0;
    vga_de = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b0;
    restart_model();

    // control tokens during blanking
    blank(4, 1'b0, 1'b1);
    n_vec++;
    assert (tmds_b === T10 && tmds_g === T00 && tmds_r === T00) else begin
      n_err++;
      $error("FAIL token_vs observed=%b/%b/%b expected=%b/%b/%b", tmds_b, tmds_g, tmds_r, T10, T00, T00);
    end
    blank(4, 1'b1, 1'b1);
    n_vec++;
    assert (tmds_b === T11) else begin
      n_err++;
      $error("FAIL token_hs_vs observed=%b expected=%b", tmds_b, T11);
    end

    // B=0x00 twice after blanking, then G=0xFF after blanking
    ia = n_app;
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    blank(2, 1'b0, 1'b0);
    ig = n_app;
    drive(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    blank(LAT + 1, 1'b0, 1'b0);
    n_vec++;
    assert (obs_b[ia] === 10'b0100000000) else begin
      n_err++;
      $error("FAIL blue00_first observed=%b expected=%b", obs_b[ia], 10'b0100000000);
    end
    n_vec++;
    assert (obs_b[ia+1] === 10'b1111111111) else begin
      n_err++;
      $error("FAIL blue00_second observed=%b expected=%b", obs_b[ia+1], 10'b1111111111);
    end
    n_vec++;
    assert (obs_g[ig] === 10'b1000000000) else begin
      n_err++;
      $error("FAIL greenFF observed=%b expected=%b", obs_g[ig], 10'b1000000000);
    end

    // single-cycle blanking gap
    for (int i = 0; i < 3; i++) drive(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
    drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
    blank(LAT + 1, 1'b0, 1'b0);

    // asynchronous reset mid-line, no clock edge in between
    for (int i = 0; i < 5; i++) drive(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
    #1 reset = 1'b1;
    vga_de = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset_held");
    reset = 1'b0;
    restart_model();

    // random lines: 720 active pixels, hsync pulse in blanking, sparse 1-cycle gaps
    for (int line = 0; line < 3; line++) begin
      bit vs;
      vs = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) blank(1, (i >= 4 && i < 8), vs);
      for (int p = 0; p < 720; p++) begin
        if ($urandom_range(0, 49) == 0) blank(1, 1'($urandom_range(0, 1)), vs);
        drive(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, vs, 1'b1);
      end
    end
    blank(LAT + 2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
